itrx_aib_phy_tx_ser_feed: RTL and testbench
===========================================

// Module: itrx_aib_phy_tx_ser_feed
// PURPOSE
//  TX-side feeder for the AIB PHY half-cycle latch stage.
//  - Accepts parallel words on a valid/ready interface.
//  - Buffers them in a 2-entry FIFO.
//  - Shifts each word out as (even,odd) bit pairs, one pair per clk, LSB pair first.
//  - Drives the data/enable inputs of the downstream enabled-high, clear-low latch cells.
// PARAMETERS
//  WORD_W    8     word width; even and >=4; NPAIR = WORD_W/2 pairs per word
//  IDLE_VAL  1'b0  level driven on dout_even/dout_odd when no pair is valid
// PORTS
//  clk        in   1       core clock; all logic on rising edge
//  rstn       in   1       reset, synchronous, active-low
//  word_in    in   WORD_W  parallel TX word
//  word_vld   in   1       word_in valid
//  word_rdy   out  1       FIFO can accept; transfer when word_vld&word_rdy at clk edge
//  ser_en     in   1       permits new words to start serialising
//  dout_even  out  1       even bit of current pair (registered)
//  dout_odd   out  1       odd bit of current pair (registered)
//  lat_en     out  1       high while dout_even/dout_odd carry a valid pair (registered)
//  busy       out  1       FIFO non-empty or shifter active
//  underrun   out  1       1-cycle pulse: word finished, ser_en=1, FIFO empty
// BEHAVIOUR
//  Reset (rstn=0 at an edge):
//  - FIFO flushed to count 0; state IDLE.
//  - dout_even/dout_odd=IDLE_VAL; lat_en=0; underrun=0.
//  - word_rdy is gated low while rstn=0; busy is low when FIFO count=0 and state=IDLE.
//  - Reset mid-word aborts the word; no partial pairs follow.
//  FIFO (2 entries, wr/rd pointers plus 2-bit count):
//  - word_rdy = rstn & (count!=2), decoded from the pre-edge count.
//  - When full, a push is refused even if a pop happens on the same edge.
//  - Push and pop on the same edge with count=1: count stays 1, and the popped entry is the older one.
//  FSM states IDLE and SHIFT; shift register sh[WORD_W-1:0]; pair counter cnt[$clog2(NPAIR)-1:0].
//  - IDLE:
//    - If ser_en & count!=0: pop into sh, cnt<=0, go to SHIFT.
//    - Otherwise hold; outputs stay IDLE_VAL with lat_en=0.
//  - SHIFT, every edge:
//    - dout_even<=sh[0], dout_odd<=sh[1], lat_en<=1.
//    - sh<=sh>>2; cnt<=cnt+1.
//  - SHIFT with cnt==NPAIR-1 (last pair):
//    - If ser_en & count!=0: pop the next word into sh and set cnt<=0. This reload is back-to-back with no bubble.
//    - Otherwise go to IDLE; outputs return to IDLE_VAL and lat_en=0 on the following edge.
//    - If ser_en=1 & count==0: underrun<=1 for one cycle.
//  - ser_en deasserted mid-word: the current word completes all NPAIR pairs. No new pop occurs until ser_en=1.
//  Latency:
//  - Word accepted at edge N into an empty FIFO with ser_en=1.
//  - Pop happens at edge N+1; first pair and lat_en=1 become visible after edge N+2.
//  - The word occupies exactly NPAIR lat_en cycles.
// TESTING (WORD_W=8, IDLE_VAL=0)
//  1 rstn=0 for 3 clks with word_vld=1 -> word_rdy=0, lat_en=0, dout=0, nothing stored; after release word_rdy=1, busy=0
//  2 push 8'hB4 with ser_en=1 -> 2 clks later (even,odd)=(0,0),(1,0),(1,1),(0,1) with lat_en=1 for 4 clks; underrun pulses once
//  3 push 8'hFF,8'h00,8'hA5 back-to-back -> 12 contiguous lat_en cycles; word_rdy drops when full; single underrun at end only
//  4 ser_en=0 after 2nd pair of 8'h3C with 1 word queued -> 8'h3C completes and lat_en drops; queued word starts 1 clk after ser_en=1
//  5 rstn=0 during 3rd pair with 2 words queued -> next edge lat_en=0, dout=0, count=0, busy=0; no further pairs emitted
//  6 push and pop on the same edge with count=1 -> count stays 1; output order matches push order

Source files
------------

// File: rtl/itrx_aib_phy_tx_ser_feed.sv
// itrx_aib_phy_tx_ser_feed: 2-entry word FIFO feeding an LSB-first (even,odd) pair serialiser
// for the AIB TX half-cycle latch stage.
module itrx_aib_phy_tx_ser_feed #(
  parameter int   WORD_W   = 8,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_vld,
  output logic              word_rdy,
  input  logic              ser_en,
  output logic              dout_even,
  output logic              dout_odd,
  output logic              lat_en,
  output logic              busy,
  output logic              underrun
);
  localparam int NPAIR = WORD_W / 2;
  localparam int CW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] mem_q [2];
  logic              wp_q, rp_q;
  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              even_q, even_d, odd_q, odd_d, lat_q, lat_d, und_q, und_d;
  logic              shifting, last, push, pop;

  assign word_rdy = rstn & (count_q != 2'd2);
  assign push     = word_vld & word_rdy;
  assign shifting = state_q == SHIFT;
  assign last     = shifting & (cnt_q == CW'(NPAIR - 1));
  // A reload on the last pair keeps the pair stream gap-free across words.
  assign pop      = (~shifting | last) & ser_en & (count_q != 2'd0);

  always_comb begin
    state_d = pop ? SHIFT : (last ? IDLE : state_q);
    sh_d    = pop ? mem_q[rp_q] : (shifting ? sh_q >> 2 : sh_q);
    cnt_d   = pop ? '0 : (shifting ? cnt_q + CW'(1) : cnt_q);
    even_d  = shifting ? sh_q[0] : IDLE_VAL;
    odd_d   = shifting ? sh_q[1] : IDLE_VAL;
    lat_d   = shifting;
    und_d   = last & ser_en & (count_q == 2'd0);
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= word_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      count_q <= 2'd0;
      sh_q    <= '0;
      cnt_q   <= '0;
      even_q  <= IDLE_VAL;
      odd_q   <= IDLE_VAL;
      lat_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_q ^ push;
      rp_q    <= rp_q ^ pop;
      count_q <= count_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      lat_q   <= lat_d;
      und_q   <= und_d;
    end
  end

  assign dout_even = even_q;
  assign dout_odd  = odd_q;
  assign lat_en    = lat_q;
  assign underrun  = und_q;
  assign busy      = (count_q != 2'd0) | shifting;
endmodule

// File: tb/tb_itrx_aib_phy_tx_ser_feed.sv
// tb_itrx_aib_phy_tx_ser_feed: directed and random stimulus checked against a queue-based
// model of word buffering and pair emission.
module tb_itrx_aib_phy_tx_ser_feed;
  localparam int NPAIR = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] word_in = '0;
  logic       word_vld = 1'b0;
  logic       ser_en = 1'b0;
  logic       word_rdy, dout_even, dout_odd, lat_en, busy, underrun;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq [$];
  logic [7:0] cw = '0;
  int         rem = 0;
  logic       ee = 1'b0, eo = 1'b0, el = 1'b0, eu = 1'b0;

  itrx_aib_phy_tx_ser_feed #(.WORD_W(8), .IDLE_VAL(1'b0)) dut (
    .clk(clk), .rstn(rstn), .word_in(word_in), .word_vld(word_vld), .word_rdy(word_rdy),
    .ser_en(ser_en), .dout_even(dout_even), .dout_odd(dout_odd), .lat_en(lat_en),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
    end
  endtask

  // One clock: drive inputs, check ready, advance the model across the edge, check outputs.
  task automatic cyc(input logic r, input logic v, input logic [7:0] w, input logic e);
    int sz, rb, k;
    logic acc;
    rstn = r; word_vld = v; word_in = w; ser_en = e;
    #1;
    chk("word_rdy", word_rdy, r && mq.size() < 2);
    if (!r) begin
      mq.delete(); rem = 0; ee = 1'b0; eo = 1'b0; el = 1'b0; eu = 1'b0;
    end else begin
      sz = mq.size(); rb = rem; acc = v && sz < 2;
      if (rb > 0) begin
        k = NPAIR - rb; ee = cw[2*k]; eo = cw[2*k+1]; el = 1'b1; rem--;
      end else begin
        ee = 1'b0; eo = 1'b0; el = 1'b0;
      end
      eu = (rb == 1) && e && sz == 0;
      if (rb <= 1 && e && sz > 0) begin
        cw = mq.pop_front(); rem = NPAIR;
      end
      if (acc) mq.push_back(w);
    end
    @(posedge clk); #1;
    chk("dout_even", dout_even, ee);
    chk("dout_odd", dout_odd, eo);
    chk("lat_en", lat_en, el);
    chk("underrun", underrun, eu);
    chk("busy", busy, mq.size() > 0 || rem > 0);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [7:0] w, input logic e);
    logic acc;
    for (int i = 0; i < 12; i++) begin
      acc = mq.size() < 2;
      cyc(1'b1, 1'b1, w, e);
      if (acc) break;
    end
  endtask

  task automatic idle(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, e);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hAA, 1'b1);
    idle(2, 1'b1);
    push_word(8'hB4, 1'b1);
    idle(8, 1'b1);
    push_word(8'hFF, 1'b1);
    push_word(8'h00, 1'b1);
    push_word(8'hA5, 1'b1);
    idle(16, 1'b1);
    push_word(8'h3C, 1'b1);
    push_word(8'h5A, 1'b1);
    idle(2, 1'b1);
    idle(8, 1'b0);
    idle(8, 1'b1);
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    idle(2, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(10, 1'b1);
    push_word(8'h44, 1'b0);
    push_word(8'h55, 1'b1);
    idle(12, 1'b1);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0);
    idle(16, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
